// File: rtl/pipeline_drain_fifo.sv
// Output FIFO behind the 3-stage globally-stalled pipeline: captures valid results,
// raises the global stall when full, and keeps saturating statistics counters.
module pipeline_drain_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_flush,
  output logic                       stall_out,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           words_accepted,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           flush_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0]    FULL_COUNT = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Stall depends on registered occupancy only, so a pop from full releases it one cycle later.
  assign stall_out = (count == FULL_COUNT);
  assign m_valid   = (count != '0);
  assign m_data    = m_valid ? mem[rd_ptr] : '0;

  assign push = in_valid & ~in_flush & ~stall_out;
  assign pop  = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + OW'(1);
      end else if (!push && pop) begin
        count <= count - OW'(1);
      end
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_accepted <= '0;
      stall_cycles   <= '0;
      flush_drops    <= '0;
    end else begin
      if (push && (words_accepted != CNT_MAX)) begin
        words_accepted <= words_accepted + CNT_W'(1);
      end
      if (stall_out && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (in_valid && in_flush && (flush_drops != CNT_MAX)) begin
        flush_drops <= flush_drops + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_drain_fifo.sv
// Self-checking bench for pipeline_drain_fifo: a queue-based model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pipeline_drain_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_flush = 1'b0;
  logic             m_ready = 1'b0;

  logic             stall_out, m_valid;
  logic [WIDTH-1:0] m_data;
  logic [OW-1:0]    count;
  logic [15:0]      words_accepted, stall_cycles, flush_drops;

  logic             stall_s, m_valid_s;
  logic [WIDTH-1:0] m_data_s;
  logic [OW-1:0]    count_s;
  logic [3:0]       words_s, stalls_s, drops_s;

  int checks = 0;
  int failures = 0;

  pipeline_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_flush(in_flush),
    .stall_out(stall_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .words_accepted(words_accepted), .stall_cycles(stall_cycles),
    .flush_drops(flush_drops)
  );

  pipeline_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_flush(in_flush),
    .stall_out(stall_s), .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready),
    .count(count_s), .words_accepted(words_s), .stall_cycles(stalls_s),
    .flush_drops(drops_s)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words and unbounded event tallies.
  logic [WIDTH-1:0] model_q[$];
  int m_words = 0;
  int m_stalls = 0;
  int m_drops = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
      m_words = 0;
      m_stalls = 0;
      m_drops = 0;
    end else begin
      automatic bit full = (model_q.size() == DEPTH);
      automatic bit do_push = in_valid && !in_flush && !full;
      automatic bit do_pop = (model_q.size() > 0) && m_ready;
      if (full) m_stalls++;
      if (in_valid && in_flush) m_drops++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(in_data);
        m_words++;
      end
    end
  end

  function automatic longint sat(int value, int bits);
    longint lim = (longint'(1) << bits) - 1;
    return (value > lim) ? lim : longint'(value);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, both instances must agree with the model.
  always @(negedge clk) begin
    automatic logic [WIDTH-1:0] exp_data = (model_q.size() > 0) ? model_q[0] : '0;
    checkOutput("model_stall", 64'(stall_out), 64'(model_q.size() == DEPTH));
    checkOutput("model_m_valid", 64'(m_valid), 64'(model_q.size() > 0));
    checkOutput("model_m_data", 64'(m_data), 64'(exp_data));
    checkOutput("model_count", 64'(count), 64'(model_q.size()));
    checkOutput("model_words", 64'(words_accepted), 64'(sat(m_words, 16)));
    checkOutput("model_stalls", 64'(stall_cycles), 64'(sat(m_stalls, 16)));
    checkOutput("model_drops", 64'(flush_drops), 64'(sat(m_drops, 16)));
    checkOutput("model_sat_data", 64'(m_data_s), 64'(exp_data));
    checkOutput("model_sat_count", 64'(count_s), 64'(model_q.size()));
    checkOutput("model_sat_words", 64'(words_s), 64'(sat(m_words, 4)));
    checkOutput("model_sat_stalls", 64'(stalls_s), 64'(sat(m_stalls, 4)));
    checkOutput("model_sat_drops", 64'(drops_s), 64'(sat(m_drops, 4)));
  end

  task automatic applyStimulus(input logic v, input logic f, input logic [WIDTH-1:0] d, input logic r);
    in_valid = v;
    in_flush = f;
    in_data  = d;
    m_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_stall"}, 64'(stall_out), 64'd0);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_m_data"}, 64'(m_data), 64'd0);
    checkOutput({tag, "_count"}, 64'(count), 64'd0);
    checkOutput({tag, "_words"}, 64'(words_accepted), 64'd0);
    checkOutput({tag, "_stalls"}, 64'(stall_cycles), 64'd0);
    checkOutput({tag, "_drops"}, 64'(flush_drops), 64'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] drain_exp [4];
    drain_exp[0] = 32'h2; drain_exp[1] = 32'h3; drain_exp[2] = 32'h4; drain_exp[3] = 32'h5;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b0;

    // Single word: visible the cycle after its push.
    applyStimulus(1, 0, 32'hDEADBEEF, 0);
    checkOutput("single_m_valid", 64'(m_valid), 64'd1);
    checkOutput("single_m_data", 64'(m_data), 64'hDEADBEEF);
    checkOutput("single_count", 64'(count), 64'd1);
    checkOutput("single_words", 64'(words_accepted), 64'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("single_drained", 64'(count), 64'd0);

    // Fill to full, then hold 0x5 while stalled.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 0, WIDTH'(i), 0);
    checkOutput("fill_count", 64'(count), 64'd4);
    checkOutput("fill_stall", 64'(stall_out), 64'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'h5, 0);
    checkOutput("held_count", 64'(count), 64'd4);
    checkOutput("held_head", 64'(m_data), 64'h1);
    checkOutput("held_stalls", 64'(stall_cycles), 64'd3);
    checkOutput("held_words", 64'(words_accepted), 64'd5);

    // Release: pop 0x1, stall drops next cycle, then 0x5 lands.
    applyStimulus(1, 0, 32'h5, 1);
    checkOutput("release_stall", 64'(stall_out), 64'd0);
    checkOutput("release_count", 64'(count), 64'd3);
    checkOutput("release_head", 64'(m_data), 64'h2);
    applyStimulus(1, 0, 32'h5, 0);
    checkOutput("refill_count", 64'(count), 64'd4);
    checkOutput("refill_words", 64'(words_accepted), 64'd6);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_order", 64'(m_data), 64'(drain_exp[i]));
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("drain_empty", 64'(m_valid), 64'd0);
    checkOutput("drain_stalls", 64'(stall_cycles), 64'd5);

    // Steady state push+pop every cycle.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 32'h100 + WIDTH'(i), 1);
      checkOutput("steady_count", 64'(count), 64'd1);
      checkOutput("steady_head", 64'(m_data), 64'(32'h100 + i));
      checkOutput("steady_stall", 64'(stall_out), 64'd0);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("steady_words", 64'(words_accepted), 64'd26);

    // Flush discards the input word but keeps stored entries.
    applyStimulus(1, 0, 32'hA1, 0);
    applyStimulus(1, 0, 32'hA2, 0);
    applyStimulus(1, 1, 32'hBAD, 0);
    checkOutput("flush_count", 64'(count), 64'd2);
    checkOutput("flush_drops", 64'(flush_drops), 64'd1);
    checkOutput("flush_head", 64'(m_data), 64'hA1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("flush_next", 64'(m_data), 64'hA2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("flush_empty", 64'(count), 64'd0);

    // Asynchronous reset in the middle of operation.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'h30 + WIDTH'(i), 0);
    checkOutput("pre_reset_count", 64'(count), 64'd3);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkResetState("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Hold full for 20 stall cycles: the 4-bit counters saturate at 15.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'h40 + WIDTH'(i), 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("sat_stalls", 64'(stalls_s), 64'd15);
    checkOutput("wide_stalls", 64'(stall_cycles), 64'd20);
    checkOutput("sat_words", 64'(words_s), 64'd4);
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, 32'hF0, 0);
    checkOutput("sat_drops", 64'(drops_s), 64'd14);
    applyStimulus(1, 1, 32'hF1, 0);
    applyStimulus(1, 1, 32'hF2, 0);
    checkOutput("sat_drops_hold", 64'(drops_s), 64'd15);
    checkOutput("wide_drops", 64'(flush_drops), 64'd16);

    doReset();
    checkResetState("final");
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
